// File: rtl/vmul_pkg.sv
// Shared types for the vector-multiplier issue sequencer: element width codes,
// sequencer states and the width of the retired result.
package vmul_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'b00,
    SEW16   = 2'b01,
    SEW32   = 2'b10,
    SEW_ILL = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } seq_state_e;

  localparam int RES_W = 128;

  // 32-bit elements need the multiplier's second (count_0=1) pass.
  function automatic logic needs_two_pass(input sew_e s);
    return (s == SEW32);
  endfunction

endpackage

// File: rtl/vmul_issue_seq.sv
// Issue/retire sequencer in front of the 8-bit-chunk vector multiplier: accepts one
// request, runs one or two multiplier passes, then holds the 128-bit result until taken.
module vmul_issue_seq
  import vmul_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sew,
  input  logic [31:0]      in_a1,
  input  logic [31:0]      in_b1,
  input  logic [31:0]      in_a2,
  input  logic [31:0]      in_b2,
  output logic             mul_start,
  output logic [1:0]       mul_sew,
  output logic             mul_count_0,
  output logic [31:0]      mul_a1,
  output logic [31:0]      mul_b1,
  output logic [31:0]      mul_a2,
  output logic [31:0]      mul_b2,
  input  logic [31:0]      mul_p1,
  input  logic [31:0]      mul_p2,
  input  logic [31:0]      mul_p3,
  input  logic [31:0]      mul_p4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  seq_state_e       state;
  seq_state_e       state_nxt;
  sew_e             req_sew;
  logic             pass;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             req_ill;
  logic             lat_done;

  assign accept   = in_valid && in_ready;
  assign req_ill  = (sew_e'(in_sew) == SEW_ILL);
  assign lat_done = (cnt == CNT_ZERO);

  // Next-state decode; busy states never look at in_valid.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_ill ? DONE : ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (lat_done) begin
          state_nxt = (needs_two_pass(req_sew) && !pass) ? ISSUE : DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state, multiplier drive registers and the retired result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_sew     <= SEW8;
      pass        <= 1'b0;
      cnt         <= CNT_ZERO;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_err     <= 1'b0;
      out_result  <= {RES_W{1'b0}};
      mul_start   <= 1'b0;
      mul_count_0 <= 1'b0;
      mul_sew     <= 2'b00;
      mul_a1      <= 32'h0000_0000;
      mul_b1      <= 32'h0000_0000;
      mul_a2      <= 32'h0000_0000;
      mul_b2      <= 32'h0000_0000;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            req_sew <= sew_e'(in_sew);
            pass    <= 1'b0;
            // An illegal width retires at once and leaves the multiplier inputs alone.
            if (req_ill) begin
              out_err    <= 1'b1;
              out_result <= {RES_W{1'b0}};
            end else begin
              out_err     <= 1'b0;
              mul_start   <= 1'b1;
              mul_count_0 <= 1'b0;
              mul_sew     <= in_sew;
              mul_a1      <= in_a1;
              mul_b1      <= in_b1;
              mul_a2      <= in_a2;
              mul_b2      <= in_b2;
            end
          end else begin
            pass <= pass;
          end
        end
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          if (lat_done) begin
            if (needs_two_pass(req_sew) && !pass) begin
              pass        <= 1'b1;
              mul_count_0 <= 1'b1;
            end else begin
              out_result <= {mul_p4, mul_p3, mul_p2, mul_p1};
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            mul_start   <= 1'b0;
            mul_count_0 <= 1'b0;
            out_err     <= 1'b0;
          end else begin
            mul_start <= mul_start;
          end
        end
        default: cnt <= CNT_ZERO;
      endcase
    end
  end

endmodule

// File: tb/tb_vmul_issue_seq.sv
// Bench for vmul_issue_seq: behavioural multiplier with latency, a transaction-level
// reference model checked every cycle, and directed requests with literal expectations.
module tb_vmul_issue_seq;

  localparam int MUL_LAT = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_sew = 2'b00;
  logic [31:0]  in_a1 = 32'd0, in_b1 = 32'd0, in_a2 = 32'd0, in_b2 = 32'd0;
  logic         mul_start, mul_count_0;
  logic [1:0]   mul_sew;
  logic [31:0]  mul_a1, mul_b1, mul_a2, mul_b2;
  logic [31:0]  mul_p1, mul_p2, mul_p3, mul_p4;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_result;
  logic         out_err;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_retired = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vmul_issue_seq #(.MUL_LAT(MUL_LAT), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sew(in_sew),
    .in_a1(in_a1), .in_b1(in_b1), .in_a2(in_a2), .in_b2(in_b2),
    .mul_start(mul_start), .mul_sew(mul_sew), .mul_count_0(mul_count_0),
    .mul_a1(mul_a1), .mul_b1(mul_b1), .mul_a2(mul_a2), .mul_b2(mul_b2),
    .mul_p1(mul_p1), .mul_p2(mul_p2), .mul_p3(mul_p3), .mul_p4(mul_p4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err)
  );

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Arithmetic meaning of one request: what {p4,p3,p2,p1} must be when it retires.
  function automatic logic [127:0] ref_result(input logic [1:0] s, input logic [31:0] a1, b1, a2, b2);
    logic [127:0] r;
    r = 128'd0;
    case (s)
      2'd0: for (int i = 0; i < 4; i++) begin
        r[16*i +: 16]      = 16'(a1[8*i +: 8]) * 16'(b1[8*i +: 8]);
        r[64 + 16*i +: 16] = 16'(a2[8*i +: 8]) * 16'(b2[8*i +: 8]);
      end
      2'd1: begin
        r[31:0]   = 32'(a1[15:0])  * 32'(b1[15:0]);
        r[63:32]  = 32'(a1[31:16]) * 32'(b1[31:16]);
        r[95:64]  = 32'(a2[15:0])  * 32'(b2[15:0]);
        r[127:96] = 32'(a2[31:16]) * 32'(b2[31:16]);
      end
      2'd2: begin
        r[63:0]   = 64'(a1) * 64'(b1);
        r[127:64] = 64'(a2) * 64'(b2);
      end
      default: r = 128'd0;
    endcase
    return r;
  endfunction

  // Multiplier stand-in: garbage until MUL_LAT edges into a pass, pass-0 of 32b is partial.
  int  age;
  logic ps, pc;
  logic [127:0] prod;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      age <= 0; ps <= 1'b0; pc <= 1'b0;
    end else begin
      ps <= mul_start;
      pc <= mul_count_0;
      if (mul_start && (!ps || mul_count_0 != pc)) age <= 1;
      else if (mul_start) age <= (age < 100) ? age + 1 : age;
      else age <= 0;
    end
  end
  always_comb begin
    if (age < MUL_LAT) prod = {4{32'hDEAD_BEEF}};
    else if (mul_sew == 2'd2 && !mul_count_0) prod = {4{32'h5A5A_A5A5}};
    else prod = ref_result(mul_sew, mul_a1, mul_b1, mul_a2, mul_b2);
  end
  assign mul_p1 = prod[31:0];
  assign mul_p2 = prod[63:32];
  assign mul_p3 = prod[95:64];
  assign mul_p4 = prod[127:96];

  // Transaction model: one request in flight, known latency per width, compared every cycle.
  initial begin
    logic         m_busy, m_err, exp_ov;
    logic [1:0]   m_sew;
    logic [127:0] m_res, m_ops;
    int           m_acc, m_due, lat;
    m_busy = 1'b0; m_err = 1'b0; m_sew = 2'd0; m_res = 128'd0; m_ops = 128'd0;
    m_acc = 0; m_due = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_busy = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_mul_ctl", {mul_start, mul_count_0, mul_sew}, 0);
        chk("rst_mul_ops", {mul_a1, mul_b1, mul_a2, mul_b2}, 0);
      end else begin
        exp_ov = m_busy && (cyc >= m_due);
        chk("in_ready", in_ready, !m_busy);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
          chk("out_result", out_result, m_res);
          chk("out_err", out_err, m_err);
        end
        chk("mul_start", mul_start, m_busy && !m_err);
        chk("mul_count_0", mul_count_0, m_busy && m_sew == 2'd2 && cyc >= m_acc + MUL_LAT + 1);
        if (m_busy && !m_err) begin
          chk("mul_sew", mul_sew, m_sew);
          chk("mul_ops", {mul_a1, mul_b1, mul_a2, mul_b2}, m_ops);
        end
        if (exp_ov && out_ready) begin
          m_busy = 1'b0;
          n_retired++;
        end else if (!m_busy && in_valid) begin
          m_busy = 1'b1;
          m_sew  = in_sew;
          m_err  = (in_sew == 2'd3);
          m_res  = ref_result(in_sew, in_a1, in_b1, in_a2, in_b2);
          m_ops  = {in_a1, in_b1, in_a2, in_b2};
          lat    = (in_sew == 2'd3) ? 1 : (in_sew == 2'd2) ? 2*MUL_LAT + 3 : MUL_LAT + 2;
          m_acc  = cyc + 1;
          m_due  = m_acc + lat - 1;
        end
      end
    end
  end

  task automatic run_req(input logic [1:0] sew, input logic [31:0] a1, b1, a2, b2, input int hold,
                         output logic [127:0] res, output logic err, output int lat, output logic started);
    int w;
    in_sew = sew; in_a1 = a1; in_b1 = b1; in_a2 = a2; in_b2 = b2; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    chk("accept_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sew = ~sew; in_a1 = ~a1; in_b1 = ~b1;
    in_a2 = 32'h1234_5678; in_b2 = 32'h9ABC_DEF0;
    lat = 1; started = mul_start;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; started |= mul_start; end
    chk("out_wait", out_valid, 1);
    res = out_result; err = out_err;
    repeat (hold) begin @(posedge clk); #1; chk("hold_in_ready", in_ready, 0); chk("hold_valid", out_valid, 1); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("retire_valid_drop", out_valid, 0);
    chk("retire_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [127:0] res;
    logic         err, started;
    int           lat, r0, w;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 16-bit halves.
    run_req(2'b01, 32'h0004_0008, 32'h0002_0003, 32'd0, 32'd0, 0, res, err, lat, started);
    chk("t1_res_lo", res[63:0], 64'h0000_0008_0000_0018);
    chk("t1_lat", lat, 5);
    chk("t1_err", err, 0);

    // Two-pass 32-bit.
    run_req(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd3, 0, res, err, lat, started);
    chk("t2_res_lo", res[63:0], 64'hFFFF_FFFE_0000_0001);
    chk("t2_res_hi", res[127:64], 64'd6);
    chk("t2_lat", lat, 9);

    // Illegal width.
    run_req(2'b11, 32'hCAFE_F00D, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 0, res, err, lat, started);
    chk("t3_lat", lat, 1);
    chk("t3_err", err, 1);
    chk("t3_res", res, 128'd0);
    chk("t3_no_start", started, 0);

    // Byte products with consumer stalling five cycles.
    run_req(2'b00, 32'h0403_0201, 32'h0506_0708, 32'd0, 32'd0, 5, res, err, lat, started);
    chk("t4_res_lo", res[63:0], 64'h0014_0012_000E_0008);
    chk("t4_lat", lat, 5);

    // Reset during pass-0 WAIT of a 32-bit request.
    in_sew = 2'b10; in_a1 = 32'h0000_0007; in_b1 = 32'h0000_0009; in_a2 = 32'd1; in_b2 = 32'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_mul_start", mul_start, 0);
    chk("t5_ctl", {mul_count_0, mul_sew, out_err}, 0);
    chk("t5_ops", {mul_a1, mul_b1, mul_a2, mul_b2}, 0);
    chk("t5_result", out_result, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (15) begin @(posedge clk); #1; chk("t5_no_valid", out_valid, 0); end

    // Back-to-back requests with in_valid held and consumer always ready.
    out_ready = 1'b1;
    r0 = n_retired;
    for (int k = 0; k < 3; k++) begin
      in_sew = 2'($urandom_range(0, 3));
      in_a1 = $urandom; in_b1 = $urandom; in_a2 = $urandom; in_b2 = $urandom;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
      chk("t6_accept_wait", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("t6_retired", n_retired - r0, 3);
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
